// File: rtl/frogger_car_mover.sv
// Frogger traffic generator: five cars in fixed lanes, each stepping one grid
// cell per lane-specific number of base ticks, wrapping at the playfield edges.
module frogger_car_mover #(
    parameter int TICK_DIV = 2500000,
    parameter int GRID_W   = 40
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Game_Active,
    input  logic [1:0] i_Level,
    output logic [5:0] o_Car_X_1,
    output logic [5:0] o_Car_X_2,
    output logic [5:0] o_Car_X_3,
    output logic [5:0] o_Car_X_4,
    output logic [5:0] o_Car_X_5,
    output logic [5:0] o_Car_Y_1,
    output logic [5:0] o_Car_Y_2,
    output logic [5:0] o_Car_Y_3,
    output logic [5:0] o_Car_Y_4,
    output logic [5:0] o_Car_Y_5,
    output logic       o_Step
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [5:0] X_MAX = 6'(GRID_W - 1);

    localparam logic [5:0] LANE_Y      [5] = '{6'd25, 6'd23, 6'd21, 6'd19, 6'd17};
    localparam logic [5:0] START_X     [5] = '{6'd0, 6'd10, 6'd20, 6'd30, 6'd5};
    localparam logic [2:0] LANE_PERIOD [5] = '{3'd4, 3'd3, 3'd6, 3'd2, 3'd5};
    localparam logic       LANE_DIR    [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [PRE_W-1:0] prescaler;
    logic [2:0]       lane_cnt  [5];
    logic [5:0]       car_x     [5];
    logic [5:0]       next_x    [5];
    logic [2:0]       eff       [5];
    logic [2:0]       shifted;
    logic [4:0]       lane_term;
    logic [4:0]       lane_step;
    logic             base_tick;

    assign base_tick = (prescaler == PRE_MAX);

    always_comb begin
        lane_term = '0;
        lane_step = '0;
        shifted   = '0;
        for (int n = 0; n < 5; n++) begin
            shifted = LANE_PERIOD[n] >> i_Level;
            eff[n]  = (shifted == 3'd0) ? 3'd1 : shifted;
            // >= rather than == so a mid-count drop in period never overruns
            lane_term[n] = (lane_cnt[n] >= (eff[n] - 3'd1));
            lane_step[n] = base_tick && lane_term[n];
            if (LANE_DIR[n])
                next_x[n] = (car_x[n] == X_MAX) ? 6'd0 : car_x[n] + 6'd1;
            else
                next_x[n] = (car_x[n] == 6'd0) ? X_MAX : car_x[n] - 6'd1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            prescaler <= '0;
            o_Step    <= 1'b0;
            for (int n = 0; n < 5; n++) begin
                lane_cnt[n] <= '0;
                car_x[n]    <= START_X[n];
            end
        end else if (!i_Game_Active) begin
            prescaler <= '0;
            o_Step    <= 1'b0;
            for (int n = 0; n < 5; n++) begin
                lane_cnt[n] <= '0;
                car_x[n]    <= START_X[n];
            end
        end else begin
            prescaler <= base_tick ? '0 : prescaler + 1'b1;
            o_Step    <= |lane_step;
            for (int n = 0; n < 5; n++) begin
                if (base_tick) begin
                    if (lane_term[n]) begin
                        car_x[n]    <= next_x[n];
                        lane_cnt[n] <= '0;
                    end else begin
                        lane_cnt[n] <= lane_cnt[n] + 3'd1;
                    end
                end
            end
        end
    end

    assign o_Car_X_1 = car_x[0];
    assign o_Car_X_2 = car_x[1];
    assign o_Car_X_3 = car_x[2];
    assign o_Car_X_4 = car_x[3];
    assign o_Car_X_5 = car_x[4];

    assign o_Car_Y_1 = LANE_Y[0];
    assign o_Car_Y_2 = LANE_Y[1];
    assign o_Car_Y_3 = LANE_Y[2];
    assign o_Car_Y_4 = LANE_Y[3];
    assign o_Car_Y_5 = LANE_Y[4];

endmodule
